// File: rtl/mips_alu_muldiv_if.sv
// Handshake/bus bundle for the mips_alu_muldiv execute unit.
//   master : issuing stage -- drives the operation fields, in_valid and
//            out_ready; observes in_ready, the result and the HI/LO state.
//   slave  : the execute unit itself.
// Operation side : in_valid/in_ready, opcode, funct, shamt, src, targ, imm,
//                  pc (PC+4), jtarget.
// Result side    : out_valid/out_ready, out_data, out_taken, out_divz, busy,
//                  hi, lo.
interface mips_alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] targ;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] jtarget;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_taken;
  logic             out_divz;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, opcode, funct, shamt, src, targ, imm, pc, jtarget, out_ready,
    input  in_ready, out_valid, out_data, out_taken, out_divz, busy, hi, lo
  );

  modport slave (
    input  in_valid, opcode, funct, shamt, src, targ, imm, pc, jtarget, out_ready,
    output in_ready, out_valid, out_data, out_taken, out_divz, busy, hi, lo
  );
endinterface

// File: rtl/mips_alu_muldiv.sv
// Multi-cycle MIPS-32 execute unit: single-cycle ALU/shift/compare/address/
// branch-target ops plus iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mips_alu_muldiv_if.slave (operation in, result out, HI/LO, busy)
// Long ops run one bit per cycle for WIDTH cycles on operand magnitudes; the
// sign is applied when the final step is written into HI/LO.
module mips_alu_muldiv #(
  parameter int WIDTH       = 32,
  parameter int SHW         = $clog2(WIDTH),
  parameter bit FAST_SINGLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_alu_muldiv_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_BEQ  = 6'b000100,
                         OP_BNE   = 6'b000101, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA   = 6'b000011,
                         F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV  = 6'b000111,
                         F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO  = 6'b010010,
                         F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV  = 6'b011010, F_DIVU = 6'b011011, F_ADD   = 6'b100000,
                         F_ADDU = 6'b100001, F_SUB  = 6'b100010, F_SUBU  = 6'b100011,
                         F_AND  = 6'b100100, F_OR   = 6'b100101, F_XOR   = 6'b100110,
                         F_NOR  = 6'b100111, F_SLT  = 6'b101010, F_SLTU  = 6'b101011;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] cneg(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  state_t state, state_nx;
  logic in_ready, accept;
  logic [WIDTH-1:0] hi_q, lo_q, out_data_q;
  logic out_valid_q, out_taken_q, divz_q;
  logic single_q, op_div, neg_q, neg_r, divz_p;
  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] wa, wb, m;

  logic signed [WIDTH-1:0] src_s, targ_s;
  logic [WIDTH-1:0] res, mag_a, mag_b;
  logic taken, is_long, is_div, is_sgn, wr_hi, wr_lo, neg_a, neg_b;

  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] wa_nx, wb_nx, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign src_s  = bus.src;
  assign targ_s = bus.targ;

  // Decode and single-cycle result
  always_comb begin
    res = '0; taken = 1'b0; is_long = 1'b0; is_div = 1'b0;
    is_sgn = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    if (bus.opcode == OP_RTYPE) begin
      case (bus.funct)
        F_ADD, F_ADDU: res = bus.src + bus.targ;
        F_SUB, F_SUBU: res = bus.src - bus.targ;
        F_AND:   res = bus.src & bus.targ;
        F_OR:    res = bus.src | bus.targ;
        F_XOR:   res = bus.src ^ bus.targ;
        F_NOR:   res = ~(bus.src | bus.targ);
        F_SLT:   res = {{(WIDTH-1){1'b0}}, src_s < targ_s};
        F_SLTU:  res = {{(WIDTH-1){1'b0}}, bus.src < bus.targ};
        F_SLL:   res = bus.targ << bus.shamt;
        F_SRL:   res = bus.targ >> bus.shamt;
        F_SRA:   res = $unsigned(targ_s >>> bus.shamt);
        F_SLLV:  res = bus.targ << bus.src[SHW-1:0];
        F_SRLV:  res = bus.targ >> bus.src[SHW-1:0];
        F_SRAV:  res = $unsigned(targ_s >>> bus.src[SHW-1:0]);
        F_MFHI:  res = hi_q;
        F_MFLO:  res = lo_q;
        F_MTHI:  begin res = bus.src; wr_hi = 1'b1; end
        F_MTLO:  begin res = bus.src; wr_lo = 1'b1; end
        F_MULT:  begin is_long = 1'b1; is_sgn = 1'b1; end
        F_MULTU: is_long = 1'b1;
        F_DIV:   begin is_long = 1'b1; is_div = 1'b1; is_sgn = 1'b1; end
        F_DIVU:  begin is_long = 1'b1; is_div = 1'b1; end
        default: res = '0;
      endcase
    end else begin
      case (bus.opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: res = bus.src + bus.imm;
        OP_ANDI: res = bus.src & bus.imm;
        OP_ORI:  res = bus.src | bus.imm;
        OP_J:    res = bus.jtarget;
        OP_BEQ:  begin taken = (bus.src == bus.targ); res = taken ? bus.pc + (bus.imm << 2) : '0; end
        OP_BNE:  begin taken = (bus.src != bus.targ); res = taken ? bus.pc + (bus.imm << 2) : '0; end
        default: res = '0;
      endcase
    end
  end

  assign neg_a = is_sgn & bus.src[WIDTH-1];
  assign neg_b = is_sgn & bus.targ[WIDTH-1];
  assign mag_a = cneg(neg_a, bus.src);
  assign mag_b = cneg(neg_b, bus.targ);

  // Iteration step. Multiply: shift-add with wa = upper half, wb = multiplier
  // shifting out LSB-first. Divide: restoring, wa = partial remainder,
  // wb = dividend shifting out MSB-first while quotient bits shift in.
  // A zero divisor naturally yields an all-ones quotient and |dividend| as
  // remainder; re-applying the dividend sign restores the dividend for HI.
  always_comb begin
    mul_sum  = {1'b0, wa} + {1'b0, m & {WIDTH{wb[0]}}};
    div_sh   = {wa, wb[WIDTH-1]};
    div_diff = div_sh - {1'b0, m};
    if (op_div) begin
      wa_nx = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      wb_nx = {wb[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      wa_nx = mul_sum[WIDTH:1];
      wb_nx = {mul_sum[0], wb[WIDTH-1:1]};
    end
    prod     = {wa_nx, wb_nx};
    prod_fix = neg_q ? -prod : prod;
    if (op_div) begin
      fin_lo = divz_p ? '1 : cneg(neg_q, wb_nx);
      fin_hi = cneg(neg_r, wa_nx);
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: if (single_q || cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.in_valid && in_ready) state_nx = (is_long || !FAST_SINGLE) ? S_BUSY : S_DONE;
  end

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Results, HI/LO and per-operation control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; single_q <= 1'b0; op_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      divz_p <= 1'b0; divz_q <= 1'b0; hi_q <= '0; lo_q <= '0; out_data_q <= '0;
      out_valid_q <= 1'b0; out_taken_q <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      single_q <= ~is_long;
      op_div   <= is_div;
      neg_q    <= neg_a ^ neg_b;
      neg_r    <= neg_a;
      divz_p   <= is_div & (bus.targ == '0);
      if (wr_hi) hi_q <= bus.src;
      if (wr_lo) lo_q <= bus.src;
      if (is_long) begin
        out_valid_q <= 1'b0;
        out_taken_q <= 1'b0;
      end else begin
        out_data_q  <= res;
        out_taken_q <= taken;
        out_valid_q <= FAST_SINGLE;
      end
    end else if (state == S_BUSY) begin
      if (single_q) begin
        out_valid_q <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          hi_q        <= fin_hi;
          lo_q        <= fin_lo;
          out_data_q  <= fin_lo;
          out_valid_q <= 1'b1;
          if (op_div) divz_q <= divz_p;
        end
      end
    end else if (state == S_DONE && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Iteration working registers carry no reset; they are loaded on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      wa <= '0;
      wb <= is_div ? mag_a : mag_b;
      m  <= is_div ? mag_b : mag_a;
    end else if (state == S_BUSY && !single_q) begin
      wa <= wa_nx;
      wb <= wb_nx;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_taken = out_taken_q;
  assign bus.out_divz  = divz_q;
  assign bus.busy      = (state == S_BUSY) && !single_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Self-checking bench for mips_alu_muldiv (WIDTH=32, FAST_SINGLE=1).
// Directed steps followed by randomized operations, each compared against a
// behavioural model built on 64-bit integer arithmetic.
module tb_mips_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_alu_muldiv_if #(.WIDTH(W)) bus ();
  mips_alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int lat, busy_cnt;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic m_divz = 1'b0;

  logic [5:0] rfn [0:23] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                             6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b010000, 6'b010001,
                             6'b010010, 6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011};
  logic [5:0] iop [0:8] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b100011,
                            6'b101011, 6'b000010, 6'b000100, 6'b000101};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sra(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
  endfunction

  // Architectural model: result, branch flag, long-op flag; updates m_hi/m_lo/m_divz
  task automatic ref_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] s, input logic [31:0] t, input logic [31:0] i,
                        input logic [31:0] p, input logic [31:0] j,
                        output logic [31:0] d, output logic tk, output logic lng);
    longint sa, ta, q, r;
    logic [63:0] pr;
    sa = $signed(s); ta = $signed(t);
    d = '0; tk = 1'b0; lng = 1'b0;
    if (opc == 6'd0) begin
      case (fn)
        6'b100000, 6'b100001: d = s + t;
        6'b100010, 6'b100011: d = s - t;
        6'b100100: d = s & t;
        6'b100101: d = s | t;
        6'b100110: d = s ^ t;
        6'b100111: d = ~(s | t);
        6'b101010: d = (sa < ta) ? 32'd1 : 32'd0;
        6'b101011: d = (s < t) ? 32'd1 : 32'd0;
        6'b000000: d = t << sh;
        6'b000010: d = t >> sh;
        6'b000011: d = sra(t, sh);
        6'b000100: d = t << s[4:0];
        6'b000110: d = t >> s[4:0];
        6'b000111: d = sra(t, s[4:0]);
        6'b010000: d = m_hi;
        6'b010010: d = m_lo;
        6'b010001: begin m_hi = s; d = s; end
        6'b010011: begin m_lo = s; d = s; end
        6'b011000: begin pr = sa * ta; {m_hi, m_lo} = pr; d = m_lo; lng = 1'b1; end
        6'b011001: begin pr = {32'd0, s} * {32'd0, t}; {m_hi, m_lo} = pr; d = m_lo; lng = 1'b1; end
        6'b011010, 6'b011011: begin
          lng = 1'b1;
          if (t == 32'd0) begin
            m_lo = 32'hFFFF_FFFF; m_hi = s; m_divz = 1'b1;
          end else begin
            if (fn == 6'b011010) begin q = sa / ta; r = sa % ta; end
            else begin q = longint'({32'd0, s}) / longint'({32'd0, t}); r = longint'({32'd0, s}) % longint'({32'd0, t}); end
            m_lo = q[31:0]; m_hi = r[31:0]; m_divz = 1'b0;
          end
          d = m_lo;
        end
        default: d = '0;
      endcase
    end else begin
      case (opc)
        6'b001000, 6'b001001, 6'b100011, 6'b101011: d = s + i;
        6'b001100: d = s & i;
        6'b001101: d = s | i;
        6'b000010: d = j;
        6'b000100: begin tk = (s == t); d = tk ? p + i * 4 : 32'd0; end
        6'b000101: begin tk = (s != t); d = tk ? p + i * 4 : 32'd0; end
        default: d = '0;
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle with out_valid
  task automatic run_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] s, input logic [31:0] t, input logic [31:0] i,
                        input logic [31:0] p, input logic [31:0] j);
    int n;
    bus.opcode = opc; bus.funct = fn; bus.shamt = sh; bus.src = s; bus.targ = t;
    bus.imm = i; bus.pc = p; bus.jtarget = j; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!bus.out_valid && lat < 80) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] s, input logic [31:0] t,
                       input logic [31:0] i, input logic [31:0] p, input logic [31:0] j);
    logic [31:0] d;
    logic tk, lng;
    ref_op(opc, fn, sh, s, t, i, p, j, d, tk, lng);
    run_op(opc, fn, sh, s, t, i, p, j);
    check({tag, ".latency"}, lat, lng ? 32'd33 : 32'd1);
    check({tag, ".data"}, bus.out_data, d);
    check({tag, ".taken"}, {31'd0, bus.out_taken}, {31'd0, tk});
    check({tag, ".hi"}, bus.hi, m_hi);
    check({tag, ".lo"}, bus.lo, m_lo);
    check({tag, ".divz"}, {31'd0, bus.out_divz}, {31'd0, m_divz});
    if (lng) check({tag, ".busy_cycles"}, busy_cnt, 32'd32);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 15));
      1: return -32'($urandom_range(1, 16));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] d, s, t, i, hold;
    logic [5:0] opc, fn;
    logic tk, lng;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = '0; bus.funct = '0;
    bus.shamt = '0; bus.src = '0; bus.targ = '0; bus.imm = '0; bus.pc = '0; bus.jtarget = '0;

    // Reset values
    #12;
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.out_data", bus.out_data, 32'd0);
    check("rst.out_taken", {31'd0, bus.out_taken}, 32'd0);
    check("rst.out_divz", {31'd0, bus.out_divz}, 32'd0);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst.hi", bus.hi, 32'd0);
    check("rst.lo", bus.lo, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Directed single-cycle and long operations
    do_op("add", 6'd0, 6'b100000, 5'd0, 32'd7, -32'd3, 0, 0, 0);
    check("add.const", bus.out_data, 32'd4);
    do_op("sra", 6'd0, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 0, 0, 0);
    check("sra.const", bus.out_data, 32'hF800_0000);
    do_op("sltu", 6'd0, 6'b101011, 5'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0);
    check("sltu.const", bus.out_data, 32'd1);
    do_op("slt", 6'd0, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0);
    check("slt.const", bus.out_data, 32'd0);
    do_op("mult", 6'd0, 6'b011000, 5'd0, -32'd3, 32'd5, 0, 0, 0);
    check("mult.hi_const", bus.hi, 32'hFFFF_FFFF);
    check("mult.lo_const", bus.lo, 32'hFFFF_FFF1);
    do_op("multu", 6'd0, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    check("multu.hi_const", bus.hi, 32'd1);
    check("multu.lo_const", bus.lo, 32'hFFFF_FFFE);
    do_op("div", 6'd0, 6'b011010, 5'd0, -32'd7, 32'd2, 0, 0, 0);
    check("div.lo_const", bus.lo, 32'hFFFF_FFFD);
    check("div.hi_const", bus.hi, 32'hFFFF_FFFF);
    do_op("divu0", 6'd0, 6'b011011, 5'd0, 32'd10, 32'd0, 0, 0, 0);
    check("divu0.lo_const", bus.lo, 32'hFFFF_FFFF);
    check("divu0.hi_const", bus.hi, 32'd10);
    check("divu0.divz_const", {31'd0, bus.out_divz}, 32'd1);
    do_op("divu", 6'd0, 6'b011011, 5'd0, 32'd10, 32'd3, 0, 0, 0);
    check("divu.divz_const", {31'd0, bus.out_divz}, 32'd0);
    do_op("mfhi", 6'd0, 6'b010000, 5'd0, 0, 0, 0, 0, 0);
    check("mfhi.const", bus.out_data, 32'd1);
    do_op("mflo", 6'd0, 6'b010010, 5'd0, 0, 0, 0, 0, 0);
    check("mflo.const", bus.out_data, 32'd3);
    do_op("beq", 6'b000100, 6'd0, 5'd0, 32'd5, 32'd5, 32'd3, 32'h100, 0);
    check("beq.taken_const", {31'd0, bus.out_taken}, 32'd1);
    check("beq.data_const", bus.out_data, 32'h10C);
    do_op("bne", 6'b000101, 6'd0, 5'd0, 32'd5, 32'd5, 32'd3, 32'h100, 0);
    check("bne.data_const", bus.out_data, 32'd0);
    do_op("j", 6'b000010, 6'd0, 5'd0, 0, 0, 0, 0, 32'h0040_1234);

    // Backpressure: result held while out_ready=0, then back-to-back accept
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    do_op("bp_add", 6'd0, 6'b100001, 5'd0, 32'd100, 32'd23, 0, 0, 0);
    hold = 32'd123;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.data", k), bus.out_data, hold);
      check($sformatf("bp.hold%0d.valid", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp.hold%0d.in_ready", k), {31'd0, bus.in_ready}, 32'd0);
    end
    ref_op(6'd0, 6'b100010, 5'd0, 32'd50, 32'd8, 0, 0, 0, d, tk, lng);
    bus.opcode = 6'd0; bus.funct = 6'b100010; bus.src = 32'd50; bus.targ = 32'd8;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("bp.in_ready_with_out_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.next_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp.next_data", bus.out_data, d);

    // Reset in the middle of a MULT
    bus.opcode = 6'd0; bus.funct = 6'b011000; bus.src = 32'h1234_5678; bus.targ = 32'h9ABC_DEF0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mrst.busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst.busy", {31'd0, bus.busy}, 32'd0);
    check("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst.out_data", bus.out_data, 32'd0);
    check("mrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mrst.hi", bus.hi, 32'd0);
    check("mrst.lo", bus.lo, 32'd0);
    m_hi = '0; m_lo = '0; m_divz = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    do_op("mrst.mflo", 6'd0, 6'b010010, 5'd0, 0, 0, 0, 0, 0);
    check("mrst.mflo_const", bus.out_data, 32'd0);

    // Randomized operations against the model
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin opc = 6'd0; fn = rfn[$urandom_range(0, 23)]; end
        6, 7, 8: begin opc = iop[$urandom_range(0, 8)]; fn = 6'($urandom); end
        default: begin opc = 6'($urandom); fn = 6'($urandom); end
      endcase
      s = rnd_val();
      t = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
      if ($urandom_range(0, 3) == 0) t = s;
      i = 32'($signed(16'($urandom)));
      do_op($sformatf("rnd%0d", k), opc, fn, 5'($urandom), s, t, i, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
